// File: rtl/frame_sender_if.sv
// rtl/frame_sender_if.sv - host/stream bus bundle for frame_sender
// Optional macro FRAME_SENDER_ALT_PATTERN_EN adds the pat_load strobe.

interface frame_sender_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic signed [WIDTH-1:0] wr_data;
  logic                    start;
  logic                    stall;
`ifdef FRAME_SENDER_ALT_PATTERN_EN
  logic                    pat_load;
`endif
  logic signed [WIDTH-1:0] dout;
  logic                    dvalid;
  logic                    sof;
  logic                    eof;
  logic                    busy;
  logic                    done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stall,
`ifdef FRAME_SENDER_ALT_PATTERN_EN
    output pat_load,
`endif
    input  dout, dvalid, sof, eof, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stall,
`ifdef FRAME_SENDER_ALT_PATTERN_EN
    input  pat_load,
`endif
    output dout, dvalid, sof, eof, busy, done
  );
endinterface

// File: rtl/frame_sender.sv
// rtl/frame_sender.sv - stores one frame of signed samples and streams it with sof/eof framing
// Optional macro FRAME_SENDER_ALT_PATTERN_EN adds a one-cycle alternating test pattern fill.

module frame_sender #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic           clk,
  input logic           rst,
  frame_sender_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_n;
  logic [AW-1:0]           idx, idx_n;
  logic [AW-1:0]           idx_inc;
  logic signed [WIDTH-1:0] mem [DEPTH];

  logic signed [WIDTH-1:0] dout_q, dout_n;
  logic                    dvalid_q, dvalid_n;
  logic                    sof_q, sof_n;
  logic                    eof_q, eof_n;
  logic                    busy_q, busy_n;
  logic                    done_q, done_n;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  assign idx_inc    = idx + AW'(1);

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.sof    = sof_q;
  assign bus.eof    = eof_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  // Frame storage: loads only while idle, and a simultaneous start drops the write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (state == IDLE && !bus.start) begin
`ifdef FRAME_SENDER_ALT_PATTERN_EN
      if (bus.pat_load) begin
        for (int k = 0; k < DEPTH; k++)
          mem[k] <= k[0] ? WIDTH'(k + 1) : -WIDTH'(k + 1);
      end else
`endif
      if (bus.wr_en) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // State, index and registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      dout_q   <= dout_n;
      dvalid_q <= dvalid_n;
      sof_q    <= sof_n;
      eof_q    <= eof_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-output decode; stall holds everything, done is a single-cycle pulse.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    dout_n   = dout_q;
    dvalid_n = dvalid_q;
    sof_n    = sof_q;
    eof_n    = eof_q;
    busy_n   = busy_q;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        dout_n   = '0;
        dvalid_n = 1'b0;
        sof_n    = 1'b0;
        eof_n    = 1'b0;
        busy_n   = 1'b0;
        if (bus.start) begin
          state_n  = SEND;
          idx_n    = '0;
          dout_n   = mem[0];
          dvalid_n = 1'b1;
          sof_n    = 1'b1;
          busy_n   = 1'b1;
        end
      end

      SEND: begin
        if (!bus.stall) begin
          if (idx == LAST) begin
            state_n  = IDLE;
            idx_n    = '0;
            dout_n   = '0;
            dvalid_n = 1'b0;
            sof_n    = 1'b0;
            eof_n    = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else begin
            idx_n  = idx_inc;
            dout_n = mem[idx_inc];
            sof_n  = 1'b0;
            eof_n  = (idx_inc == LAST);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/frame_sender.md
Name: frame_sender

Overview:
- Transmit-side counterpart of the 16-sample signed min/max consumer.
- Holds one frame of DEPTH signed samples, loaded by a host write port.
- On start, streams the frame one sample per clock onto a registered din-style bus with valid/sof/eof framing.
- Supports downstream stall; signals a one-cycle done pulse at frame end.

Parameters:
- WIDTH, 16, sample width in bits (two's complement)
- DEPTH, 16, samples per frame (power of two, >= 2)
- AW, 4, address width = log2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- wr_en  input  1  host write strobe
- wr_addr  input  AW  host write address
- wr_data  input  WIDTH  signed sample to store
- start  input  1  begin transmitting the stored frame
- stall  input  1  downstream back-pressure; hold current sample
- dout  output  WIDTH  signed sample out, registered
- dvalid  output  1  dout carries a frame sample
- sof  output  1  first sample of frame (with dvalid)
- eof  output  1  last sample of frame (with dvalid)
- busy  output  1  frame transmission in progress
- done  output  1  one-cycle pulse after last sample accepted

Behaviour:
- Reset (rst=0, async):
  - state IDLE; idx=0.
  - dout=0; dvalid, sof, eof, busy, done all 0.
  - All DEPTH memory entries cleared to 0.
  - Reset mid-frame aborts immediately; no done pulse is issued.
- States: IDLE, SEND.
- IDLE:
  - wr_en=1 and start=0 at posedge: mem[wr_addr] <= wr_data.
  - wr_en=1 with start=1 in the same cycle: the write is dropped; start wins.
  - start=1 at posedge: go to SEND; idx=0; dout<=mem[0]; dvalid=1; sof=1; busy=1.
  - Latency: first sample is visible in the cycle after start is sampled.
- SEND, each posedge:
  - stall=1: all outputs and idx held; dvalid stays 1. Stall applies only in SEND.
  - stall=0 and idx<DEPTH-1: idx++; dout<=mem[idx+1]; sof=0; eof=1 iff idx+1==DEPTH-1.
  - stall=0 and idx==DEPTH-1: go to IDLE; dout=0; dvalid, sof, eof, busy=0; done=1 for exactly one cycle.
- A sample counts as transferred on any posedge where dvalid=1 and stall=0.
- Unstalled frame length: exactly DEPTH consecutive dvalid cycles.
- start while busy: ignored; no restart, no queuing.
- wr_en while busy: ignored; the frame is never corrupted mid-send.
- start during the done cycle (state already IDLE): accepted at that edge; new sof follows immediately, giving one idle gap cycle between frames.
- done and dvalid are never high together.
- sof and eof are only high while dvalid=1.
- The data path performs no arithmetic; samples pass bit-exact, sign preserved.

Optional Feature:
- Macro: FRAME_SENDER_ALT_PATTERN_EN.
- Defined:
  - Adds input port pat_load (1 bit).
  - pat_load=1 in IDLE (start=0) at posedge fills the memory with mem[k] = (k+1)*(-1)^(k+1), i.e. -1, 2, -3, 4, ..., +DEPTH, in one cycle.
  - pat_load has priority over wr_en in the same cycle.
  - pat_load is ignored while busy.
- Not defined: port absent; memory is loaded only via wr_en.

Test Plan:
- Reset, then write mem[k]=k*100 for k=0..15, then pulse start → next 16 cycles dout=0,100,...,1500. sof only on 0, eof only on 1500. The following cycle has done=1, dvalid=0, dout=0.
- Write mem[3]=16'h8000 (-32768) and mem[4]=16'h7FFF, then start → dout reproduces -32768 and 32767 bit-exact at indices 3 and 4.
- Hold stall=1 for 3 cycles while dout=mem[5] → dout, eof, and busy frozen for 3 cycles. Frame still delivers 16 unique samples; done arrives 3 cycles later than the unstalled case.
- Mid-frame, assert start and wr_en (addr 9, data 7) → frame unaffected, no restart. After done, mem[9] still holds its old value.
- Drive rst=0 asynchronously (mid-cycle) at idx=8 → dvalid, busy, dout go 0 immediately, no done pulse. After release, start sends an all-zero frame.
- With FRAME_SENDER_ALT_PATTERN_EN: pat_load then start → dout sequence -1, 2, -3, ..., -15, 16; done one cycle after 16.
